// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel frame controller.
package sipo_pkg;

    // Control FSM states: waiting for a start-of-frame, or collecting bits.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } sipo_state_t;

endpackage : sipo_pkg

// File: rtl/sipo_shift_en.sv
// WIDTH-stage shift chain with synchronous reset and shift enable.
// New bits enter at the LSB and move toward the MSB one stage per enabled cycle.
module sipo_shift_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] chain_d;

    // Next chain value: shift one stage when enabled, otherwise hold.
    always_comb begin
        chain_d = chain_q;
        if (en) begin
            chain_d = {chain_q[WIDTH-2:0], d};
        end
    end

    // Chain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q;

endmodule : sipo_shift_en

// File: rtl/sipo_frame_ctrl.sv
// Frames a bit-serial stream into WIDTH-bit words and hands each completed word
// to a downstream consumer.
//
// Output handshake: a word moves from pout to the consumer on any rising edge
// where pout_vld=1 and pout_rdy=1. pout_vld never drops without such a transfer,
// pout is held stable while pout_vld=1 and pout_rdy=0, and pout_rdy is ignored
// while pout_vld=0. A newly completed word may load on the same edge as a
// transfer, in which case pout_vld stays high.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] pout,
    output logic             pout_vld,
    input  logic             pout_rdy,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sipo_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_vld_q, pout_vld_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             shift_en;
    logic [WIDTH-1:0] chain;
    logic             restart;
    logic             complete;
    logic             slot_free;

    // A bit is shifted whenever it starts a frame or belongs to one. A sof
    // inside a frame also shifts: the restarted frame overwrites every stage
    // before it can complete, so stale bits never reach pout.
    always_comb begin
        shift_en  = sin_vld && ((state_q == ST_COLLECT) || sof);
        restart   = sin_vld && sof && (state_q == ST_COLLECT);
        complete  = sin_vld && !sof && (state_q == ST_COLLECT) && (bit_cnt_q == LAST_CNT);
        slot_free = !pout_vld_q || pout_rdy;
    end

    sipo_shift_en #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   (sin),
        .q   (chain)
    );

    // Next-state logic for the FSM, bit counter, output slot and sticky flags.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pout_d      = pout_q;
        pout_vld_d  = pout_vld_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        // Consumer transfer frees the slot unless a new word refills it below.
        if (pout_vld_q && pout_rdy) begin
            pout_vld_d = 1'b0;
        end

        if (err_clr) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sin_vld && sof) begin
                    state_d   = ST_COLLECT;
                    bit_cnt_d = CNT_W'(1);
                end
            end
            ST_COLLECT: begin
                if (restart) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = CNT_W'(1);
                end else if (complete) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (slot_free) begin
                        pout_d     = {chain[WIDTH-2:0], sin};
                        pout_vld_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (sin_vld) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        busy_d = (state_d == ST_COLLECT);
    end

    // Control registers; reset overrides all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            pout_q      <= '0;
            pout_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pout_q      <= pout_d;
            pout_vld_q  <= pout_vld_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pout      = pout_q;
    assign pout_vld  = pout_vld_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule : sipo_frame_ctrl

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with WIDTH=4.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             sin;
    logic             sin_vld;
    logic             sof;
    logic [WIDTH-1:0] pout;
    logic             pout_vld;
    logic             pout_rdy;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    int vectors     = 0;
    int miscompares = 0;

    sipo_frame_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_vld   (sin_vld),
        .sof       (sof),
        .pout      (pout),
        .pout_vld  (pout_vld),
        .pout_rdy  (pout_rdy),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    // Clock.
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one serial bit for a single cycle.
    task automatic bit_in(input logic b, input logic s);
        sin     = b;
        sin_vld = 1'b1;
        sof     = s;
        step();
        sin     = 1'b0;
        sin_vld = 1'b0;
        sof     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        sin      = 1'b0;
        sin_vld  = 1'b0;
        sof      = 1'b0;
        pout_rdy = 1'b0;
        err_clr  = 1'b0;
        idle(2);
        check("rst_pout",      32'(pout),      32'h0);
        check("rst_pout_vld",  32'(pout_vld),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle(1);

        // 1: contiguous frame 1011, consumer ready.
        pout_rdy = 1'b1;
        bit_in(1'b1, 1'b1);
        check("t1_busy_first", 32'(busy), 32'h1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        check("t1_vld_early", 32'(pout_vld), 32'h0);
        bit_in(1'b1, 1'b0);
        check("t1_pout",      32'(pout),     32'hB);
        check("t1_vld",       32'(pout_vld), 32'h1);
        check("t1_busy_done", 32'(busy),     32'h0);
        // Back-to-back frame 0100 starting right after completion.
        bit_in(1'b0, 1'b1);
        check("t1_vld_drop", 32'(pout_vld), 32'h0);
        check("t1_b2b_busy", 32'(busy),     32'h1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        check("t1_b2b_pout", 32'(pout),     32'h4);
        check("t1_b2b_vld",  32'(pout_vld), 32'h1);
        idle(1);
        check("t1_b2b_drop", 32'(pout_vld), 32'h0);

        // 2: same frame with 2-cycle gaps between bits.
        bit_in(1'b1, 1'b1);
        idle(2);
        check("t2_busy_gap1", 32'(busy), 32'h1);
        bit_in(1'b0, 1'b0);
        idle(2);
        check("t2_busy_gap2", 32'(busy), 32'h1);
        bit_in(1'b1, 1'b0);
        idle(2);
        check("t2_busy_gap3", 32'(busy),     32'h1);
        check("t2_vld_gap3",  32'(pout_vld), 32'h0);
        bit_in(1'b1, 1'b0);
        check("t2_pout", 32'(pout),     32'hB);
        check("t2_vld",  32'(pout_vld), 32'h1);
        idle(1);
        check("t2_drop", 32'(pout_vld), 32'h0);

        // 3: consumer stalled, second frame overruns.
        pout_rdy = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        check("t3_first_vld", 32'(pout_vld), 32'h1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        check("t3_held_pout", 32'(pout),     32'hB);
        check("t3_held_vld",  32'(pout_vld), 32'h1);
        check("t3_overrun",   32'(overrun),  32'h1);
        idle(2);
        check("t3_sticky", 32'(overrun), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_clr",       32'(overrun),  32'h0);
        check("t3_still_vld", 32'(pout_vld), 32'h1);
        // 3b: word still held; a new frame loads on the same edge as the transfer.
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        pout_rdy = 1'b1;
        bit_in(1'b1, 1'b0);
        check("t3b_pout",    32'(pout),     32'h3);
        check("t3b_vld",     32'(pout_vld), 32'h1);
        check("t3b_overrun", 32'(overrun),  32'h0);
        idle(1);
        check("t3b_drop", 32'(pout_vld), 32'h0);

        // 4: sof mid-frame restarts and flags frame_err.
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1);
        check("t4_frame_err", 32'(frame_err), 32'h1);
        check("t4_busy",      32'(busy),      32'h1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        check("t4_no_early", 32'(pout_vld), 32'h0);
        bit_in(1'b1, 1'b0);
        check("t4_pout", 32'(pout),     32'h1);
        check("t4_vld",  32'(pout_vld), 32'h1);
        idle(1);
        check("t4_drop", 32'(pout_vld), 32'h0);
        // Set has priority over a simultaneous clear: sof on the completing bit.
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        err_clr = 1'b1;
        bit_in(1'b1, 1'b1);
        err_clr = 1'b0;
        check("t4_sof_last_err",  32'(frame_err), 32'h1);
        check("t4_sof_last_vld",  32'(pout_vld),  32'h0);
        check("t4_sof_last_busy", 32'(busy),      32'h1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("t4_restart_pout", 32'(pout),     32'hA);
        check("t4_restart_vld",  32'(pout_vld), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_clr", 32'(frame_err), 32'h0);

        // 5: bits without sof in IDLE are ignored.
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        check("t5_vld",  32'(pout_vld), 32'h0);
        check("t5_busy", 32'(busy),     32'h0);
        check("t5_pout", 32'(pout),     32'hA);

        // 6: reset in mid-frame, then a fresh frame 0110.
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_pout",      32'(pout),      32'h0);
        check("t6_vld",       32'(pout_vld),  32'h0);
        check("t6_busy",      32'(busy),      32'h0);
        check("t6_overrun",   32'(overrun),   32'h0);
        check("t6_frame_err", 32'(frame_err), 32'h0);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("t6_fresh_pout", 32'(pout),      32'h6);
        check("t6_fresh_vld",  32'(pout_vld),  32'h1);
        check("t6_fresh_ferr", 32'(frame_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound the run so a stuck design cannot hang the simulator.
    initial begin
        #100000;
        $display("FAIL timeout vectors=%0d expected_finish=yes", vectors);
        $fatal(1, "timeout");
    end

endmodule : tb_sipo_frame_ctrl
